// File: rtl/stack_cmd_queue.sv
// rtl/stack_cmd_queue.sv - command FIFO and single-outstanding issuer for the stack model
// Buffers push/pop commands, presents them one at a time, and returns each result on a response channel.
module stack_cmd_queue #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              valid,
   input  logic              ready,
   output logic              write,
   output logic [DATA_W-1:0] data_wr,
   input  logic [DATA_W-1:0] data_rd,
   input  logic              err,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [LW-1:0]     level
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state;
   state_t          state_next;
   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic            has_work;

   assign cmd_ready = (level != LW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = valid && ready;
   assign write     = mem[rd_ptr][DATA_W];
   assign data_wr   = mem[rd_ptr][DATA_W-1:0];
   assign valid     = (state == ISSUE);
   assign rsp_valid = (state == RESP);
   // A push landing this cycle counts as work so a fresh command issues on the next cycle.
   assign has_work  = (level != '0) || push;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_data};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rsp_write <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (pop) begin
            rsp_write <= write;
            rsp_data  <= write ? '0 : data_rd;
            rsp_err   <= err;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (has_work) state_next = ISSUE;
         ISSUE:   if (ready) state_next = RESP;
         RESP:    if (rsp_ready) state_next = has_work ? ISSUE : IDLE;
         default: state_next = IDLE;
      endcase
   end
endmodule
